noc_port_trace_unit: RTL

Parametrised design-for-debug (DfD) trace unit that replaces the fixed single-word `trigger`/`trace` pair in the router top level. It snoops the P router input ports and records header flits into a circular trace buffer with cycle timestamps. It fires a configurable trigger (packet count, deadlock watchdog or payload match), keeps capturing for a programmable post-trigger window, then freezes the buffer for readout. It sits beside `inout_ports` and taps `flit_in_all`/`flit_in_we_all`.

---
 rtl/noc_port_trace_unit_pkg.sv | 40 ++++
 rtl/noc_port_trace_unit_ring_buffer.sv | 79 +++++++
 rtl/noc_port_trace_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_port_trace_unit_pkg.sv
// rtl/noc_port_trace_unit_pkg.sv - shared types and encodings for the port trace unit
package noc_port_trace_unit_pkg;

   // trace entry field layout (LSB positions)
   localparam int ENT_TS_LSB   = 16;
   localparam int ENT_PORT_LSB = 12;
   localparam int ENT_VC_LSB   = 8;
   localparam int ENT_PAY_LSB  = 0;

   // trig_mode encodings
   localparam logic [1:0] MODE_COUNT = 2'd0;
   localparam logic [1:0] MODE_WDOG  = 2'd1;
   localparam logic [1:0] MODE_MATCH = 2'd2;
   localparam logic [1:0] MODE_NEVER = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_POST   = 2'd2,
      ST_FROZEN = 2'd3
   } trace_state_e;

   typedef struct packed {
      logic [15:0] ts;
      logic [3:0]  port;
      logic [3:0]  vc;
      logic [7:0]  pay;
   } trace_entry_t;

   // port index base+offset wrapped into 0..ports-1 (offset < ports)
   function automatic logic [3:0] rr_index(input logic [3:0] base,
                                           input int unsigned offset,
                                           input int unsigned ports);
      int unsigned s;
      s = 32'(base) + offset;
      if (s >= ports) s = s - ports;
      return 4'(s);
   endfunction

endpackage

// File: rtl/noc_port_trace_unit_ring_buffer.sv
// rtl/noc_port_trace_unit_ring_buffer.sv - circular trace store with overwrite and registered read
module trace_ring_buffer
   import noc_port_trace_unit_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr_i,
   input  logic                     wr_i,
   input  trace_entry_t             wdata_i,
   input  logic                     rd_i,
   output trace_entry_t             rdata_o,
   output logic                     rvalid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   trace_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   trace_entry_t  rdata_q;
   logic          rvalid_q;
   logic          full;
   logic          rd_ok;

   assign full  = (count_q == FULL_CNT);
   assign rd_ok = rd_i && (count_q != '0) && !clr_i;

   // next pointers and occupancy; writing into a full ring evicts the oldest entry
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_ok || (wr_i && full)) rd_ptr_d = rd_ptr_q + AW'(1);
         if (wr_i && !rd_ok && !full) count_d = count_q + (AW+1)'(1);
         else if (rd_ok && !wr_i)     count_d = count_q - (AW+1)'(1);
      end
   end

   // pointer/occupancy state and the registered read port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rvalid_q <= rd_ok;
         if (rd_ok) rdata_q <= mem_q[rd_ptr_q];
      end
   end

   // entry storage; contents are meaningless until counted, so no reset
   always_ff @(posedge clk) begin
      if (wr_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign count_o  = count_q;
   assign empty_o  = (count_q == '0);

endmodule

// File: rtl/noc_port_trace_unit.sv
// rtl/noc_port_trace_unit.sv - router input-port header tracer with trigger and post-trigger window
module noc_port_trace_unit
   import noc_port_trace_unit_pkg::*;
#(
   parameter int P         = 5,
   parameter int V         = 4,
   parameter int Fpay      = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int CNTw      = 16
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [P*(2+V+Fpay)-1:0]     flit_in_all,
   input  logic [P-1:0]                flit_in_we_all,
   input  logic                        trig_en,
   input  logic [P-1:0]                trig_port_mask,
   input  logic [1:0]                  trig_mode,
   input  logic [CNTw-1:0]             trig_threshold,
   input  logic                        trace_rd,
   output logic                        trigger,
   output logic [31:0]                 trace,
   output logic                        trace_valid,
   output logic                        trace_empty,
   output logic [$clog2(DEPTH):0]      trace_count,
   output logic [CNTw-1:0]             drop_cnt,
   output logic [1:0]                  state
);

   localparam int Fw = 2 + V + Fpay;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CNTw + 5;
   localparam logic [CNTw-1:0] CNT_MAX = {CNTw{1'b1}};

   trace_state_e    state_q;
   logic            trigger_q;
   logic            trig_en_q;
   logic [CW-1:0]   post_cnt_q;
   logic [15:0]     ts_q;
   logic [3:0]      rr_ptr_q;
   logic [CNTw-1:0] drop_q, drop_d;
   logic [CNTw-1:0] total_q, total_d;
   logic [CNTw-1:0] wd_q, wd_d;

   logic [15:0]     cand;
   logic [15:0]     masked_we;
   logic [4:0]      n_cand;
   logic [3:0]      port_vc  [16];
   logic [7:0]      port_pay [16];
   logic            win_found;
   logic [3:0]      win_idx;
   logic [SW-1:0]   drop_sum, total_sum;
   trace_entry_t    cap_entry, rd_entry;
   logic            capturing, cap_wr, arm, rd_ok, fire, any_we;
   logic            unused_flit_bits;

   assign unused_flit_bits = ^flit_in_all;

   // decode every snooped flit: masked valid, candidate header, VC index, low payload byte
   always_comb begin
      cand      = '0;
      masked_we = '0;
      n_cand    = '0;
      for (int i = 0; i < 16; i++) begin
         port_vc[i]  = '0;
         port_pay[i] = '0;
      end
      for (int i = 0; i < P; i++) begin
         masked_we[i] = flit_in_we_all[i] & trig_port_mask[i];
         cand[i]      = masked_we[i] & flit_in_all[i*Fw + Fw - 1];
         port_pay[i]  = flit_in_all[i*Fw +: 8];
         for (int j = V - 1; j >= 0; j--) begin
            if (flit_in_all[i*Fw + Fpay + j]) port_vc[i] = 4'(j);
         end
         n_cand = n_cand + 5'(cand[i]);
      end
   end

   // round-robin winner: first candidate at or after the pointer
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < P; k++) begin
         if (!win_found && cand[rr_index(rr_ptr_q, k, P)]) begin
            win_found = 1'b1;
            win_idx   = rr_index(rr_ptr_q, k, P);
         end
      end
   end

   assign any_we    = |masked_we;
   assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
   assign cap_wr    = capturing && win_found;
   assign cap_entry = {ts_q, win_idx, port_vc[win_idx], port_pay[win_idx]};
   assign arm       = trig_en && !trig_en_q && (state_q == ST_IDLE);
   assign rd_ok     = trace_rd && !trace_empty && !arm &&
                      ((state_q == ST_IDLE) || (state_q == ST_FROZEN));

   // saturating next values for drop, header-total and idle-run counters
   always_comb begin
      drop_sum  = SW'(drop_q) + SW'(n_cand) - SW'(1);
      total_sum = SW'(total_q) + SW'(n_cand);
      drop_d    = (drop_sum > SW'(CNT_MAX))  ? CNT_MAX : drop_sum[CNTw-1:0];
      total_d   = (total_sum > SW'(CNT_MAX)) ? CNT_MAX : total_sum[CNTw-1:0];
      if (any_we)              wd_d = '0;
      else if (wd_q == CNT_MAX) wd_d = wd_q;
      else                      wd_d = wd_q + CNTw'(1);
   end

   // trigger condition, only meaningful while armed; zero threshold disables it
   always_comb begin
      fire = 1'b0;
      case (trig_mode)
         MODE_COUNT: fire = (total_sum >= SW'(trig_threshold));
         MODE_WDOG:  fire = (wd_q >= trig_threshold);
         MODE_MATCH: fire = cap_wr && (cap_entry.pay == trig_threshold[7:0]);
         MODE_NEVER: fire = 1'b0;
         default:    fire = 1'b0;
      endcase
      fire = fire && (|trig_threshold) && (state_q == ST_ARMED);
   end

   // timestamp, arm-edge detect, arbitration pointer and trigger accounting counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q      <= '0;
         trig_en_q <= 1'b0;
         rr_ptr_q  <= '0;
         drop_q    <= '0;
         total_q   <= '0;
         wd_q      <= '0;
      end else begin
         ts_q      <= ts_q + 16'd1;
         trig_en_q <= trig_en;
         if (arm) begin
            rr_ptr_q <= '0;
            drop_q   <= '0;
            total_q  <= '0;
            wd_q     <= '0;
         end else begin
            if (cap_wr) begin
               rr_ptr_q <= rr_index(win_idx, 1, P);
               drop_q   <= drop_d;
            end
            if (state_q == ST_ARMED) begin
               total_q <= total_d;
               wd_q    <= wd_d;
            end
         end
      end
   end

   // capture FSM with sticky trigger flag and post-trigger entry count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         trigger_q  <= 1'b0;
         post_cnt_q <= '0;
      end else if (!trig_en) begin
         state_q   <= ST_IDLE;
         trigger_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_q    <= ST_ARMED;
                  post_cnt_q <= '0;
               end
            end
            ST_ARMED: begin
               if (fire) begin
                  trigger_q  <= 1'b1;
                  post_cnt_q <= '0;
                  state_q    <= (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
               end
            end
            ST_POST: begin
               if (cap_wr) begin
                  post_cnt_q <= post_cnt_q + CW'(1);
                  if (post_cnt_q == CW'(POST_TRIG - 1)) state_q <= ST_FROZEN;
               end
            end
            default: ;
         endcase
      end
   end

   trace_ring_buffer #(.DEPTH(DEPTH)) u_ring (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (arm),
      .wr_i     (cap_wr),
      .wdata_i  (cap_entry),
      .rd_i     (rd_ok),
      .rdata_o  (rd_entry),
      .rvalid_o (trace_valid),
      .count_o  (trace_count),
      .empty_o  (trace_empty)
   );

   assign trace    = rd_entry;
   assign trigger  = trigger_q;
   assign drop_cnt = drop_q;
   assign state    = state_q;

endmodule
